// File: rtl/fifo_byte_reader_pkg.sv
// fifo_byte_reader_pkg: state encodings and byte-index constants for the capture byte reader
package fifo_byte_reader_pkg;
  typedef enum logic [1:0] {EMPTY, FETCH, WAIT, LOADED} state_t;
  localparam logic [1:0] BYTE_LO  = 2'd0;
  localparam logic [1:0] BYTE_HI  = 2'd1;
  localparam logic [1:0] BYTE_TOP = 2'd2;
endpackage

// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader: pops 18-bit capture words and serves them as three bytes per word
module fifo_byte_reader
  import fifo_byte_reader_pkg::*;
#(
  parameter logic [7:0] pEMPTY_BYTE = 8'hFF,
  parameter int         pCOUNT_W    = 16
) (
  input  logic                cwusb_clk,
  input  logic                reset_n,
  input  logic [17:0]         I_fifo_data,
  input  logic                I_fifo_empty,
  output logic                O_fifo_read,
  input  logic                I_byte_read,
  input  logic                I_flush,
  input  logic                I_clear_flags,
  output logic [7:0]          O_byte,
  output logic                O_byte_valid,
  output logic                O_underrun,
  output logic [pCOUNT_W-1:0] O_word_count
);
  state_t      state, state_nx;
  logic [17:0] word_q;
  logic [1:0]  idx;
  logic        last_read;
  assign last_read    = state == LOADED && I_byte_read && idx == BYTE_TOP;
  assign O_fifo_read  = state == FETCH && !I_flush;
  assign O_byte_valid = state == LOADED;
  assign O_byte       = !O_byte_valid     ? pEMPTY_BYTE :
                        idx == BYTE_LO    ? word_q[7:0] :
                        idx == BYTE_HI    ? word_q[15:8] : {6'b0, word_q[17:16]};
  // Refetch only when the FIFO already shows data, so no pop ever hits an empty FIFO.
  always_comb begin
    state_nx = I_flush         ? EMPTY :
               state == EMPTY  ? (I_fifo_empty ? EMPTY : FETCH) :
               state == FETCH  ? WAIT :
               state == WAIT   ? LOADED :
               last_read       ? (I_fifo_empty ? EMPTY : FETCH) : LOADED;
  end
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMPTY;
      word_q       <= '0;
      idx          <= BYTE_LO;
      O_underrun   <= 1'b0;
      O_word_count <= '0;
    end else begin
      state        <= state_nx;
      if (state == WAIT && !I_flush) word_q <= I_fifo_data;
      idx          <= (I_flush || state == WAIT || last_read) ? BYTE_LO :
                      (state == LOADED && I_byte_read) ? idx + 2'd1 : idx;
      O_underrun   <= (I_byte_read && state != LOADED) ? 1'b1 :
                      I_clear_flags ? 1'b0 : O_underrun;
      O_word_count <= I_flush ? '0 :
                      (last_read && O_word_count != '1) ? O_word_count + pCOUNT_W'(1) : O_word_count;
    end
  end
endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb_fifo_byte_reader: directed checks of the byte reader against a small FIFO model
module tb_fifo_byte_reader;
  logic        cwusb_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] I_fifo_data = '0;
  logic        I_fifo_empty;
  logic        I_byte_read = 1'b0, I_flush = 1'b0, I_clear_flags = 1'b0;
  logic        O_fifo_read, O_byte_valid, O_underrun;
  logic [7:0]  O_byte;
  logic [15:0] O_word_count;
  logic        rd4, valid4, under4;
  logic [7:0]  byte4;
  logic [3:0]  cnt4;
  logic [17:0] mem [0:63];
  int          push_cnt = 0, pop_cnt = 0, bad_pop = 0;
  int          checks = 0, failures = 0;
  int          base;

  always #5 cwusb_clk = ~cwusb_clk;

  assign I_fifo_empty = pop_cnt >= push_cnt;

  always @(posedge cwusb_clk) if (O_fifo_read) begin
    if (pop_cnt < push_cnt) I_fifo_data <= mem[pop_cnt];
    else bad_pop <= bad_pop + 1;
    pop_cnt <= pop_cnt + 1;
  end

  fifo_byte_reader dut (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n), .I_fifo_data(I_fifo_data),
    .I_fifo_empty(I_fifo_empty), .O_fifo_read(O_fifo_read), .I_byte_read(I_byte_read),
    .I_flush(I_flush), .I_clear_flags(I_clear_flags), .O_byte(O_byte),
    .O_byte_valid(O_byte_valid), .O_underrun(O_underrun), .O_word_count(O_word_count)
  );

  fifo_byte_reader #(.pCOUNT_W(4)) dut4 (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n), .I_fifo_data(I_fifo_data),
    .I_fifo_empty(I_fifo_empty), .O_fifo_read(rd4), .I_byte_read(I_byte_read),
    .I_flush(I_flush), .I_clear_flags(I_clear_flags), .O_byte(byte4),
    .O_byte_valid(valid4), .O_underrun(under4), .O_word_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cwusb_clk);
    #1;
  endtask

  task automatic push(input logic [17:0] d);
    mem[push_cnt] = d;
    push_cnt++;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !O_byte_valid; i++) step();
    chk(tag, {31'b0, O_byte_valid}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'b0, O_byte_valid}, 32'd1);
    chk(tag, {24'b0, O_byte}, {24'b0, exp});
    I_byte_read = 1'b1;
    step();
    I_byte_read = 1'b0;
  endtask

  task automatic rd_under(input string tag);
    chk({tag, "_byte"}, {24'b0, O_byte}, 32'hFF);
    I_byte_read = 1'b1;
    step();
    I_byte_read = 1'b0;
    chk({tag, "_flag"}, {31'b0, O_underrun}, 32'd1);
  endtask

  task automatic flush_pulse();
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_read", {31'b0, O_fifo_read}, 0);
    chk("rst_valid", {31'b0, O_byte_valid}, 0);
    chk("rst_byte", {24'b0, O_byte}, 32'hFF);
    chk("rst_under", {31'b0, O_underrun}, 0);
    chk("rst_count", {16'b0, O_word_count}, 0);
    reset_n = 1'b1;
    step();
    // single word, refill latency
    push(18'h2A5C3);
    step();
    chk("t1_read_pulse", {31'b0, O_fifo_read}, 1);
    step();
    chk("t1_read_low", {31'b0, O_fifo_read}, 0);
    chk("t1_not_yet", {31'b0, O_byte_valid}, 0);
    step();
    chk("t1_valid_at3", {31'b0, O_byte_valid}, 1);
    rd("t1_b0", 8'hC3);
    rd("t1_b1", 8'hA5);
    rd("t1_b2", 8'h02);
    chk("t1_count", {16'b0, O_word_count}, 1);
    chk("t1_pops", pop_cnt, 1);
    chk("t1_empty_after", {31'b0, O_byte_valid}, 0);
    // two words, reads spaced 4 cycles
    flush_pulse();
    base = pop_cnt;
    push(18'h00011);
    push(18'h3FFFF);
    wait_valid("t2_wait");
    rd("t2_b0", 8'h11); repeat (3) step();
    rd("t2_b1", 8'h00); repeat (3) step();
    rd("t2_b2", 8'h00); repeat (3) step();
    rd("t2_b3", 8'hFF); repeat (3) step();
    rd("t2_b4", 8'hFF); repeat (3) step();
    rd("t2_b5", 8'h03); repeat (3) step();
    chk("t2_pops", pop_cnt - base, 2);
    chk("t2_count", {16'b0, O_word_count}, 2);
    chk("t2_under", {31'b0, O_underrun}, 0);
    // underrun and clear
    rd_under("t3_under");
    chk("t3_count_kept", {16'b0, O_word_count}, 2);
    I_clear_flags = 1'b1; step(); I_clear_flags = 1'b0;
    chk("t3_cleared", {31'b0, O_underrun}, 0);
    I_clear_flags = 1'b1;
    rd_under("t3_set_wins");
    I_clear_flags = 1'b1; step(); I_clear_flags = 1'b0;
    // flush during WAIT drops the word
    push(18'h12345);
    step();
    chk("t4_fetch", {31'b0, O_fifo_read}, 1);
    step();
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    chk("t4_dropped", {31'b0, O_byte_valid}, 0);
    chk("t4_count0", {16'b0, O_word_count}, 0);
    repeat (4) step();
    chk("t4_still_empty", {31'b0, O_byte_valid}, 0);
    rd_under("t4_under");
    // flush held with data queued: no pop until release
    base = pop_cnt;
    push(18'h1ABCD);
    I_flush = 1'b1;
    step();
    chk("t4_no_read_in_flush", {31'b0, O_fifo_read}, 0);
    step();
    I_flush = 1'b0;
    chk("t4_no_pop", pop_cnt - base, 0);
    step();
    chk("t4_fetch_after", {31'b0, O_fifo_read}, 1);
    wait_valid("t4_wait");
    rd("t4_b0", 8'hCD);
    rd("t4_b1", 8'hAB);
    rd("t4_b2", 8'h01);
    // saturation on the 4-bit counter
    flush_pulse();
    for (int i = 0; i < 17; i++) push(18'(i + 'h40));
    for (int i = 0; i < 17; i++) begin
      wait_valid("t5_wait");
      rd("t5_lo", 8'(i + 'h40));
      rd("t5_hi", 8'h00);
      rd("t5_top", 8'h00);
    end
    chk("t5_count16", {16'b0, O_word_count}, 17);
    chk("t5_count4_sat", {28'b0, cnt4}, 32'hF);
    // asynchronous reset mid-word
    rd_under("t6_pre_under");
    push(18'h2A5C3);
    wait_valid("t6_wait");
    rd("t6_b0", 8'hC3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", {31'b0, O_byte_valid}, 0);
    chk("t6_byte", {24'b0, O_byte}, 32'hFF);
    chk("t6_under", {31'b0, O_underrun}, 0);
    chk("t6_count", {16'b0, O_word_count}, 0);
    chk("t6_count4", {28'b0, cnt4}, 0);
    chk("t6_read", {31'b0, O_fifo_read}, 0);
    chk("no_bad_pop", bad_pop, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_byte_reader.md
# fifo_byte_reader

Downstream read-side stage of the PhyWhisperer capture FIFO, on `cwusb_clk`. It pops 18-bit capture words from the FIFO read port, holds one word, and serves it to the USB register interface as three bytes, one per register read strobe. It also tracks read underruns and counts the words consumed.

## Interface
Parameters:
- `pEMPTY_BYTE`, default 8'hFF: value returned on a read when no word is held.
- `pCOUNT_W`, default 16: width of the consumed-word counter.

Ports:
- `cwusb_clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset. The block has one clock; reset is asynchronous and active-low.
- `I_fifo_data` in 18: FIFO `O_data`. Valid on the cycle after `O_fifo_read`.
- `I_fifo_empty` in 1: FIFO empty flag, read-clock domain.
- `O_fifo_read` out 1: single-cycle pop pulse to the FIFO `I_fifo_read`.
- `I_byte_read` in 1: one-cycle strobe per USB byte read from reg_main.
- `I_flush` in 1: level; discard the held word and in-flight fetch.
- `I_clear_flags` in 1: clears `O_underrun`.
- `O_byte` out 8: current byte. Equals `pEMPTY_BYTE` when `O_byte_valid`=0.
- `O_byte_valid` out 1: a word is held.
- `O_underrun` out 1: sticky; set when a read arrives while `O_byte_valid`=0.
- `O_word_count` out pCOUNT_W: number of words fully consumed since the last flush or reset.

## Operation
- FSM states: EMPTY, FETCH, WAIT, LOADED. Reset state is EMPTY.
  - EMPTY → FETCH when `!I_fifo_empty && !I_flush`.
  - FETCH: `O_fifo_read`=1 for exactly this cycle, then go to WAIT.
  - WAIT: latch `I_fifo_data` into the word register, set `idx`=0, go to LOADED.
  - LOADED: on `I_byte_read`:
    - if `idx`<2, `idx`+1;
    - if `idx`==2, increment `O_word_count`, then go to FETCH if `!I_fifo_empty`, otherwise to EMPTY.
- Byte mapping by `idx`:
  - 0 → data[7:0]
  - 1 → data[15:8]
  - 2 → {6'b0, data[17:16]}
- `O_byte` is a combinational mux of the word register and `idx`. `O_byte_valid` = (state==LOADED).
- `I_byte_read` outside LOADED: return `pEMPTY_BYTE`, set `O_underrun`, change no other state.
- `I_flush` has priority over everything except reset:
  - next state EMPTY, `idx`=0, `O_word_count`=0;
  - `O_fifo_read` is forced low in the flush cycle;
  - if the flush lands in WAIT, the arriving data is dropped.
  - `O_underrun` is not affected by flush.
- `O_underrun`: set has priority over `I_clear_flags` in the same cycle.
- `O_word_count` saturates at all-ones and does not wrap.
- Reset values:
  - `O_fifo_read`=0, `O_byte_valid`=0, `O_byte`=`pEMPTY_BYTE`, `O_underrun`=0, `O_word_count`=0, `idx`=0.
  - Word register = 0.

## Timing
- Refill latency from `I_fifo_empty` falling, in EMPTY: `O_fifo_read` at +1 cycle, `O_byte_valid` at +3 cycles.
- Word-to-word latency: after the third byte read, the next word is valid 3 cycles later if the FIFO is non-empty. Reads issued inside that gap underrun. reg_main read spacing of ≥4 cycles guarantees no underrun while the FIFO is non-empty.
- Only one fetch is ever outstanding. `O_fifo_read` is never asserted while `I_fifo_empty`=1 at the decision cycle, so the FIFO underflow flag never fires because of this block.
- Reset deassertion is synchronised externally. Reset mid-FETCH may leave one popped word unread; this is acceptable because the FIFO is reset in the same event.

## Structure
- State encodings and the byte-index constants (`BYTE_LO`=0, `BYTE_HI`=1, `BYTE_TOP`=2) go in `defines_pw.v`.
- Single module; no sub-module is warranted. The byte mux stays inline.

## Test plan
- Reset, then FIFO non-empty holding 18'h2A5C3 → `O_fifo_read` pulses once; after 3 cycles, three reads return 8'hC3, 8'hA5, 8'h02; `O_word_count`=1.
- Two words queued (18'h00011, 18'h3FFFF), reads spaced 4 cycles → bytes 11,00,00,FF,FF,03; exactly 2 `O_fifo_read` pulses; count=2; `O_underrun`=0.
- Read while EMPTY → `O_byte`=FF, `O_underrun`=1, count unchanged. `I_clear_flags` → `O_underrun`=0. Read plus clear in the same cycle → `O_underrun`=1.
- `I_flush` asserted during WAIT → word dropped, state EMPTY, count=0. Next read underruns unless the FIFO is non-empty, in which case a new fetch starts once flush is released.
- With pCOUNT_W=4, consume 17 words → `O_word_count` holds at 4'hF.
- Assert `reset_n` low asynchronously while in LOADED with `idx`=1 → outputs take reset values immediately, without a clock edge.
